// File: rtl/dice_pkg.sv
// Shared widths, default seeds, LFSR taps and the LFSR-to-dice mapping
// used by the dual-dice random source.
package dice_pkg;

  localparam int LFSR_W = 16;
  localparam int DICE_W = 4;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED1 = 16'hACE1;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED2 = 16'h1D87;

  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    logic fb;
    fb = l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D];
    return {l[LFSR_W-2:0], fb};
  endfunction

  // Nibbles 10..15 fold down onto 4..9 so every value stays a legal digit.
  function automatic logic [DICE_W-1:0] dice_map(input logic [LFSR_W-1:0] l);
    logic [DICE_W-1:0] n;
    n = l[DICE_W-1:0];
    if (n <= 4'd9) return n;
    else return n - 4'd6;
  endfunction

endpackage

// File: rtl/dice_lfsr.sv
// One free-running LFSR generator plus its roll-capture dice register.
module dice_lfsr
  import dice_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              roll,
  input  logic              finish,
  output logic [DICE_W-1:0] dice
);

  logic [LFSR_W-1:0] lfsr;

  // The all-zero state is a lock-up for this LFSR, so it reloads the seed.
  // The dice capture uses the pre-step LFSR value and is blocked by finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
      dice <= '0;
    end else begin
      if (lfsr == '0) lfsr <= SEED;
      else            lfsr <= lfsr_next(lfsr);
      if (!finish && roll) dice <= dice_map(lfsr);
    end
  end

endmodule

// File: rtl/dice_rng_core.sv
// Dual-dice random source with a synchronised, debounced player key that
// produces one-cycle press/release pulses.
module dice_rng_core
  import dice_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED1           = DEFAULT_SEED1,
  parameter logic [LFSR_W-1:0] SEED2           = DEFAULT_SEED2,
  parameter int                DEBOUNCE_CYCLES = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              roll1,
  input  logic              roll2,
  input  logic              finish,
  input  logic              key_in,
  output logic [DICE_W-1:0] dice1,
  output logic [DICE_W-1:0] dice2,
  output logic              key_pressed,
  output logic              key_released
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  dice_lfsr #(.SEED(SEED1)) u_gen1 (
    .clk    (clk),
    .rst    (rst),
    .roll   (roll1),
    .finish (finish),
    .dice   (dice1)
  );

  dice_lfsr #(.SEED(SEED2)) u_gen2 (
    .clk    (clk),
    .rst    (rst),
    .roll   (roll2),
    .finish (finish),
    .dice   (dice2)
  );

  logic             key_meta;
  logic             ks;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // A level change is accepted only after it has persisted for the whole
  // debounce window; any return to the stable level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta     <= 1'b0;
      ks           <= 1'b0;
      stable       <= 1'b0;
      cnt          <= '0;
      key_pressed  <= 1'b0;
      key_released <= 1'b0;
    end else begin
      key_meta     <= key_in;
      ks           <= key_meta;
      key_pressed  <= 1'b0;
      key_released <= 1'b0;
      if (ks == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable       <= ks;
        cnt          <= '0;
        key_pressed  <= ks;
        key_released <= ~ks;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dice_rng_core.sv
// Directed self-checking bench for dice_rng_core: reset, rolls, freeze,
// mapping boundaries, debounce latency and bounce rejection.
module tb_dice_rng_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       roll1, roll2, finish, key_in;
  logic       bnd_roll;
  logic [3:0] dice1, dice2;
  logic       key_pressed, key_released;

  logic [3:0] ba_d1, ba_d2, bb_d1, bb_d2;
  logic       ba_kp, ba_kr, bb_kp, bb_kr;

  int checks = 0;
  int fails  = 0;

  logic [15:0] m1, m2;
  logic [3:0]  exp1, exp2;

  always #5 clk = ~clk;

  dice_rng_core u_dut (
    .clk(clk), .rst(rst), .roll1(roll1), .roll2(roll2), .finish(finish),
    .key_in(key_in), .dice1(dice1), .dice2(dice2),
    .key_pressed(key_pressed), .key_released(key_released)
  );

  dice_rng_core #(.SEED1(16'h1239), .SEED2(16'h543A)) u_bnd_a (
    .clk(clk), .rst(rst), .roll1(bnd_roll), .roll2(bnd_roll), .finish(1'b0),
    .key_in(1'b0), .dice1(ba_d1), .dice2(ba_d2),
    .key_pressed(ba_kp), .key_released(ba_kr)
  );

  dice_rng_core #(.SEED1(16'h000F), .SEED2(16'hF00F)) u_bnd_b (
    .clk(clk), .rst(rst), .roll1(bnd_roll), .roll2(bnd_roll), .finish(1'b0),
    .key_in(1'b0), .dice1(bb_d1), .dice2(bb_d2),
    .key_pressed(bb_kp), .key_released(bb_kr)
  );

  function automatic logic [3:0] ref_map(input logic [15:0] l);
    int n;
    n = int'(l[3:0]);
    if (n > 9) n = n - 6;
    return 4'(n);
  endfunction

  function automatic logic [15:0] ref_step(input logic [15:0] l);
    if (l == 16'h0000) return l;
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference generators for the default-seed instance.
  always @(posedge clk) begin
    if (rst) begin
      m1 <= 16'hACE1; m2 <= 16'h1D87; exp1 <= 4'd0; exp2 <= 4'd0;
    end else begin
      m1 <= (m1 == 16'h0000) ? 16'hACE1 : ref_step(m1);
      m2 <= (m2 == 16'h0000) ? 16'h1D87 : ref_step(m2);
      if (!finish && roll1) exp1 <= ref_map(m1);
      if (!finish && roll2) exp2 <= ref_map(m2);
    end
  end

  task automatic test_reset;
    rst = 1'b1; roll1 = 1'b1; roll2 = 1'b1; finish = 1'b0; key_in = 1'b0; bnd_roll = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dice1 !== 4'd0) begin fails++; $display("[TB] FAIL reset_dice1 got %0d expected 0", dice1); end
    checks++; if (dice2 !== 4'd0) begin fails++; $display("[TB] FAIL reset_dice2 got %0d expected 0", dice2); end
    checks++; if (key_pressed !== 1'b0) begin fails++; $display("[TB] FAIL reset_key_pressed got %b expected 0", key_pressed); end
    checks++; if (key_released !== 1'b0) begin fails++; $display("[TB] FAIL reset_key_released got %b expected 0", key_released); end
    checks++; if (m1 !== 16'hACE1 || m2 !== 16'h1D87) begin fails++; $display("[TB] FAIL reset_model got %h/%h expected ace1/1d87", m1, m2); end
    rst = 1'b0; roll1 = 1'b0; roll2 = 1'b0;
  endtask

  task automatic test_roll_sequence;
    for (int e = 1; e <= 45; e++) begin
      roll1 = (e == 5 || e == 17 || e == 40);
      @(negedge clk);
      if (e == 5) begin
        checks++; if (dice1 !== 4'd8) begin fails++; $display("[TB] FAIL roll_edge5_hand got %0d expected 8", dice1); end
      end
      checks++; if (dice1 !== exp1) begin fails++; $display("[TB] FAIL roll_dice1 edge %0d got %0d expected %0d", e, dice1, exp1); end
      checks++; if (dice1 > 4'd9) begin fails++; $display("[TB] FAIL roll_range got %0d expected <=9", dice1); end
      checks++; if (dice2 !== 4'd0) begin fails++; $display("[TB] FAIL roll_dice2_idle got %0d expected 0", dice2); end
    end
    roll1 = 1'b0;
  endtask

  task automatic test_freeze;
    logic [3:0] hold1, hold2;
    hold1 = '0; hold2 = '0;
    roll1 = 1'b1; roll2 = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      finish = (e >= 30 && e <= 37);
      @(negedge clk);
      if (e == 29) begin hold1 = exp1; hold2 = exp2; end
      if (finish) begin
        checks++; if (dice1 !== hold1 || dice2 !== hold2) begin
          fails++; $display("[TB] FAIL freeze_hold edge %0d got %0d/%0d expected %0d/%0d", e, dice1, dice2, hold1, hold2);
        end
      end
      checks++; if (dice1 !== exp1 || dice2 !== exp2) begin
        fails++; $display("[TB] FAIL freeze_track edge %0d got %0d/%0d expected %0d/%0d", e, dice1, dice2, exp1, exp2);
      end
    end
    finish = 1'b0; roll1 = 1'b0; roll2 = 1'b0;
  endtask

  task automatic test_map_bounds;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bnd_roll = 1'b1;
    @(negedge clk);
    bnd_roll = 1'b0;
    checks++; if (ba_d1 !== 4'd9) begin fails++; $display("[TB] FAIL map_nib9 got %0d expected 9", ba_d1); end
    checks++; if (ba_d2 !== 4'd4) begin fails++; $display("[TB] FAIL map_nib10 got %0d expected 4", ba_d2); end
    checks++; if (bb_d1 !== 4'd9) begin fails++; $display("[TB] FAIL map_nib15 got %0d expected 9", bb_d1); end
    checks++; if (bb_d2 !== 4'd9) begin fails++; $display("[TB] FAIL map_nib15_b got %0d expected 9", bb_d2); end
  endtask

  task automatic test_reset_mid;
    key_in = 1'b1;
    repeat (12) @(negedge clk);
    rst = 1'b1; key_in = 1'b0;
    @(negedge clk);
    checks++; if (key_pressed !== 1'b0 || dice1 !== 4'd0) begin
      fails++; $display("[TB] FAIL midreset_clear got kp=%b d1=%0d expected 0/0", key_pressed, dice1);
    end
    rst = 1'b0; roll1 = 1'b1; roll2 = 1'b1;
    @(negedge clk);
    roll1 = 1'b0; roll2 = 1'b0;
    checks++; if (dice1 !== 4'd1) begin fails++; $display("[TB] FAIL midreset_seed1 got %0d expected 1", dice1); end
    checks++; if (dice2 !== 4'd7) begin fails++; $display("[TB] FAIL midreset_seed2 got %0d expected 7", dice2); end
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      checks++; if (key_pressed !== 1'b0 || key_released !== 1'b0) begin
        fails++; $display("[TB] FAIL midreset_no_pulse edge %0d got %b/%b expected 0/0", n, key_pressed, key_released);
      end
    end
  endtask

  task automatic test_clean_press;
    key_in = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      checks++; if (key_pressed !== (n == 22) || key_released !== 1'b0) begin
        fails++; $display("[TB] FAIL press_pulse edge %0d got %b/%b expected %b/0", n, key_pressed, key_released, (n == 22));
      end
    end
    key_in = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      checks++; if (key_released !== (n == 22) || key_pressed !== 1'b0) begin
        fails++; $display("[TB] FAIL release_pulse edge %0d got %b/%b expected %b/0", n, key_released, key_pressed, (n == 22));
      end
    end
  endtask

  task automatic test_bounce;
    key_in = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      if (n == 11) key_in = 1'b0;
      @(negedge clk);
      checks++; if (key_pressed !== 1'b0 || key_released !== 1'b0) begin
        fails++; $display("[TB] FAIL bounce_early edge %0d got %b/%b expected 0/0", n, key_pressed, key_released);
      end
    end
    key_in = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      checks++; if (key_pressed !== (n == 22) || key_released !== 1'b0) begin
        fails++; $display("[TB] FAIL bounce_press edge %0d got %b/%b expected %b/0", n, key_pressed, key_released, (n == 22));
      end
    end
    key_in = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; roll1 = 1'b0; roll2 = 1'b0; finish = 1'b0; key_in = 1'b0; bnd_roll = 1'b0;
    @(negedge clk);
    $display("[TB] starting dice_rng_core tests");
    test_reset();
    test_roll_sequence();
    test_freeze();
    test_map_bounds();
    test_reset_mid();
    test_clean_press();
    test_bounce();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dice_rng_core.md
Name: dice_rng_core

Overview:
Dual-dice random source with a key debouncer for the dice game datapath.
- Two independent 16-bit LFSR generators run continuously. Each one latches a new dice value 0..9 when its roll strobe is asserted.
- A shared finish input freezes both dice values.
- A debouncer turns the raw player key into clean one-cycle press/release pulses for the upstream controller, which generates roll1/roll2.

Parameters:
SEED1, 16'hACE1, reset/reload value of generator 1 LFSR (must be nonzero)
SEED2, 16'h1D87, reset/reload value of generator 2 LFSR (must be nonzero, must differ from SEED1)
DEBOUNCE_CYCLES, 20, consecutive stable cycles needed to accept a key change (20 ms at 1 kHz clk)

Ports:
clk  in  1  system clock (nominal 1 kHz); single clock domain
rst  in  1  synchronous, active-high reset
roll1  in  1  level-sampled roll request, generator 1
roll2  in  1  level-sampled roll request, generator 2
finish  in  1  freeze: while high, dice1/dice2 hold their values
key_in  in  1  raw asynchronous push-button, active-high = pressed
dice1  out  4  dice value 0..9, generator 1
dice2  out  4  dice value 0..9, generator 2
key_pressed  out  1  one-cycle pulse on accepted press
key_released  out  1  one-cycle pulse on accepted release

Behaviour:
- Reset (synchronous, on a clk edge with rst=1):
  - lfsr1=SEED1, lfsr2=SEED2.
  - dice1=dice2=0, key_pressed=key_released=0.
  - Sync flops, stable state and debounce counter cleared to 0.
- LFSR, both generators:
  - Fibonacci step every cycle with rst=0: fb = l[15]^l[13]^l[12]^l[10]; l <= {l[14:0], fb}.
  - If l==0 (illegal state), reload the generator's seed on that edge instead of stepping.
- Dice mapping, function m(l):
  - n = l[3:0]; m = n if n<=9, else n-6 (so 10..15 map to 4..9).
  - The result is always in 0..9.
- Roll:
  - On an edge with rst=0, finish=0, rollX=1: diceX <= m(current lfsrX), using the pre-step value.
  - Output is visible one cycle after the sampled edge.
  - Holding rollX high for k cycles updates diceX on each of those k edges.
- finish=1 has priority over roll: both dice hold and both LFSRs keep stepping.
- roll1 and roll2 are fully independent. Simultaneous assertion updates both dice on the same edge.
- Debounce:
  - key_in passes through a 2-flop synchronizer giving ks.
  - While ks == stable: counter=0.
  - While ks != stable: counter increments each cycle.
  - On the edge where counter == DEBOUNCE_CYCLES-1 and ks != stable:
    - stable <= ks and counter <= 0.
    - key_pressed <= ks (rising accept) and key_released <= ~ks (falling accept), registered on that same edge.
  - On all other edges both pulses are 0.
  - Latency: a clean step on key_in produces its pulse DEBOUNCE_CYCLES+2 edges after key_in is first sampled high.
  - Any bounce back to the stable level before acceptance restarts the count.
- Reset mid-operation:
  - Aborts any pending debounce and clears the outputs on that edge.
  - The next roll after reset uses the SEED-derived sequence.

Decomposition:
- Package dice_pkg holds:
  - LFSR_W=16 and DICE_W=4.
  - Default seeds.
  - The tap positions.
  - The mapping function m.
- Sub-module dice_lfsr (params SEED) holds one LFSR, the roll/finish capture and the dice register. It is instantiated twice.
- The debouncer stays inline in dice_rng_core, or optionally as sub-module key_debounce.

Test Plan:
- Reset: hold rst=1 for 3 edges with roll1=roll2=1 -> dice1=dice2=0, no key pulses. A compare model tracks lfsr1=ACE1 and lfsr2=1D87 at the first post-reset edge.
- Roll sequence: pulse roll1 for one cycle at edges 5, 17 and 40 -> dice1 equals m(model lfsr1) at each edge, always <=9, and dice2 stays 0.
- Freeze: roll1=roll2=1 continuously, assert finish at edge 30 -> dice values are constant while finish=1 and resume matching the model on the first edge after finish drops.
- Mapping boundaries: force or choose seeds that put l[3:0] at 9, 10 and 15 -> dice=9, 4 and 9.
- Debounce clean press: key_in 0->1 held 50 cycles -> single key_pressed pulse exactly 22 edges after the first high sample. On release, a single key_released pulse 22 edges later.
- Bounce: key_in high for 10 cycles, low 2, high 40 -> no pulse after the first 10-cycle burst, then exactly one key_pressed pulse, 22 edges after the final rise.
